// File: rtl/multi_tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tick_pkg
//  Purpose  : Shared channel state encoding and sizing helper for the
//             multi-channel tick generator.
//  Revision : 1.0 - initial release
// ============================================================================
package multi_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// ============================================================================
//  Module   : tick_chan
//  Purpose  : One tick channel: IDLE/RUN/DONE control, period counter,
//             divisor with shadowed run-time update, TICK/WAVE/DONE outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_chan
    import multi_tick_pkg::*;
#(
    parameter int CNT_W   = 21,
    parameter int DEF_DIV = 1_250_000
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             ONESHOT,
    input  logic             SYNC,
    input  logic             WE,
    input  logic [CNT_W-1:0] WDATA,
    output logic             TICK,
    output logic             WAVE,
    output logic             PEND,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_tick;
    logic             r_wave;
    logic             r_done;

    logic [CNT_W-1:0] w_last;
    logic             w_term;

    // A divisor of 0 behaves like 1, so the terminal count is 0 for both.
    assign w_last = (r_div == '0) ? '0 : (r_div - 1'b1);
    assign w_term = (r_state == ST_RUN) && (r_cnt == w_last);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_div    <= c_DEF_DIV;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_wave   <= 1'b0;
            r_done   <= 1'b0;
        end else if (SYNC) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_wave <= 1'b0;
            r_pend <= 1'b0;
            if (WE) begin
                r_div <= WDATA;
            end else if (r_pend) begin
                r_div <= r_shadow;
            end
            if (r_state == ST_DONE && EN) begin
                r_state <= ST_RUN;
                r_done  <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_wave <= 1'b0;
                    r_done <= 1'b0;
                    r_pend <= 1'b0;
                    if (WE) r_div <= WDATA;
                    if (EN) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!EN) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_tick  <= 1'b0;
                        r_wave  <= 1'b0;
                        r_pend  <= 1'b0;
                        if (WE) begin
                            r_div <= WDATA;
                        end else if (r_pend) begin
                            r_div <= r_shadow;
                        end
                    end else if (w_term) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                        r_wave <= ~r_wave;
                        if (r_pend) r_div <= r_shadow;
                        // A write landing on the terminal edge waits for the next one.
                        if (WE) begin
                            r_shadow <= WDATA;
                            r_pend   <= 1'b1;
                        end else begin
                            r_pend <= 1'b0;
                        end
                        if (ONESHOT) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_tick <= 1'b0;
                        if (WE) begin
                            r_shadow <= WDATA;
                            r_pend   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    if (WE) begin
                        r_div  <= WDATA;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_div  <= r_shadow;
                        r_pend <= 1'b0;
                    end
                    if (!EN) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_wave  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_tick  <= 1'b0;
                    r_wave  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    assign TICK = r_tick;
    assign WAVE = r_wave;
    assign PEND = r_pend;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: rtl/multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tick_gen
//  Purpose  : NCH independent programmable tick channels with a shared
//             divisor write port and a global SYNC restart.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_tick_gen
    import multi_tick_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 21,
    parameter int DEF_DIV = 1_250_000
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NCH-1:0]               CH_EN,
    input  logic [NCH-1:0]               ONESHOT,
    input  logic                         SYNC,
    input  logic                         DIV_WE,
    input  logic [clog2_min1(NCH)-1:0]   DIV_SEL,
    input  logic [CNT_W-1:0]             DIV_DATA,
    output logic [NCH-1:0]               TICK,
    output logic [NCH-1:0]               WAVE,
    output logic [NCH-1:0]               PEND,
    output logic [NCH-1:0]               DONE
);

    logic [NCH-1:0] w_we;

    // Selects at or beyond NCH match no channel and are dropped.
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            assign w_we[i] = DIV_WE && (int'(DIV_SEL) == i);

            tick_chan #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV)
            ) u_chan (
                .CLK     (CLK),
                .RSTN    (RSTN),
                .EN      (CH_EN[i]),
                .ONESHOT (ONESHOT[i]),
                .SYNC    (SYNC),
                .WE      (w_we[i]),
                .WDATA   (DIV_DATA),
                .TICK    (TICK[i]),
                .WAVE    (WAVE[i]),
                .PEND    (PEND[i]),
                .DONE    (DONE[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_tick_gen
//  Purpose  : Directed self-checking bench for multi_tick_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_tick_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] ch_en, oneshot;
    logic       sync, div_we;
    logic [1:0] div_sel;
    logic [7:0] div_data;
    logic [3:0] tick, wave, pend, done;

    logic [4:0] ch_en5, oneshot5;
    logic       div_we5;
    logic [2:0] div_sel5;
    logic [7:0] div_data5;
    logic [4:0] tick5, wave5, pend5, done5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_tick_gen #(.NCH(4), .CNT_W(8), .DEF_DIV(5)) u_dut (
        .CLK(clk), .RSTN(rstn), .CH_EN(ch_en), .ONESHOT(oneshot), .SYNC(sync),
        .DIV_WE(div_we), .DIV_SEL(div_sel), .DIV_DATA(div_data),
        .TICK(tick), .WAVE(wave), .PEND(pend), .DONE(done)
    );

    // Five channels so that a select of 5 is representable yet out of range.
    multi_tick_gen #(.NCH(5), .CNT_W(8), .DEF_DIV(5)) u_dut5 (
        .CLK(clk), .RSTN(rstn), .CH_EN(ch_en5), .ONESHOT(oneshot5), .SYNC(sync),
        .DIV_WE(div_we5), .DIV_SEL(div_sel5), .DIV_DATA(div_data5),
        .TICK(tick5), .WAVE(wave5), .PEND(pend5), .DONE(done5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_div(input logic [1:0] sel, input logic [7:0] d);
        div_we   = 1'b1;
        div_sel  = sel;
        div_data = d;
        step();
        div_we   = 1'b0;
    endtask

    initial begin
        int cnt;
        logic tk, wv;
        rstn = 1'b0; ch_en = '0; oneshot = '0; sync = 1'b0;
        div_we = 1'b0; div_sel = '0; div_data = '0;
        ch_en5 = '0; oneshot5 = '0; div_we5 = 1'b0; div_sel5 = '0; div_data5 = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("reset outs c%0d", i), 32'({wave, tick, pend, done}), 32'h0);
        end
        check_val("reset outs nch5", 32'({wave5, tick5, pend5, done5}), 32'h0);

        // Default divisor 5 on channel 0
        rstn = 1'b1; ch_en = 4'b0001;
        step();
        check_val("enable edge", 32'({wave, tick, pend, done}), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            tk = (k % 5 == 0);
            wv = ((k / 5) % 2 == 1);
            check_val($sformatf("def div k=%0d", k), 32'({wave, tick}), 32'({3'b0, wv, 3'b0, tk}));
        end
        ch_en = 4'b0000;
        step();
        check_val("disable clears", 32'({wave, tick}), 32'h0);

        // Divisor 0 and 1 tick every cycle
        write_div(2'd1, 8'd0);
        ch_en = 4'b0010;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            wv = (k % 2 == 1);
            check_val($sformatf("d0 k=%0d", k), 32'({wave, tick}), 32'({2'b0, wv, 1'b0, 4'b0010}));
        end
        ch_en = 4'b0000;
        step();
        write_div(2'd1, 8'd1);
        ch_en = 4'b0010;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            wv = (k % 2 == 1);
            check_val($sformatf("d1 k=%0d", k), 32'({wave, tick}), 32'({2'b0, wv, 1'b0, 4'b0010}));
        end
        ch_en = 4'b0000;
        step();
        write_div(2'd1, 8'd255);
        ch_en = 4'b0010;
        step();
        cnt = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 255)      check_val("d255 tick", 32'(tick), 32'h2);
            else if (k == 256) check_val("d255 after", 32'(tick), 32'h0);
            else if (tick != 4'b0000) cnt++;
        end
        check_val("d255 early ticks", 32'(cnt), 32'd0);
        ch_en = 4'b0000;
        step();

        // Shadowed write: write 3 while channel 0 (D=5) sits at cnt=1
        ch_en = 4'b0001;
        step();
        step();
        write_div(2'd0, 8'd3);
        check_val("shadow pend e2", 32'(pend), 32'h1);
        step(); step();
        check_val("shadow e4", 32'({pend, tick}), 32'h10);
        step();
        check_val("shadow e5", 32'({pend, tick}), 32'h01);
        step(); step();
        check_val("period3 e7", 32'(tick), 32'h0);
        step();
        check_val("period3 e8", 32'(tick), 32'h1);
        step(); step(); step();
        check_val("period3 e11", 32'(tick), 32'h1);

        // Two writes while pending: only the last (4) is used
        div_we = 1'b1; div_sel = 2'd0; div_data = 8'd7;
        step();
        div_data = 8'd4;
        step();
        div_we = 1'b0;
        check_val("overwrite pend", 32'(pend), 32'h1);
        step();
        check_val("overwrite e14", 32'({pend, tick}), 32'h01);
        step(); step(); step();
        check_val("period4 e17", 32'(tick), 32'h0);
        step();
        check_val("period4 e18", 32'(tick), 32'h1);
        step(); step(); step(); step();
        check_val("period4 e22", 32'(tick), 32'h1);
        ch_en = 4'b0000;
        step();

        // One-shot on channel 2 with D=4
        write_div(2'd2, 8'd4);
        oneshot = 4'b0100; ch_en = 4'b0100;
        step();
        step(); step(); step();
        check_val("oneshot e3", 32'({done, tick}), 32'h00);
        step();
        check_val("oneshot e4", 32'({done, tick}), 32'h44);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (tick != 4'b0000) cnt++;
        end
        check_val("oneshot no more", 32'(cnt), 32'd0);
        check_val("oneshot done hold", 32'({done, wave}), 32'h44);
        ch_en = 4'b0000;
        step();
        check_val("oneshot cleared", 32'({done, wave}), 32'h00);
        ch_en = 4'b0100;
        step();
        step(); step(); step(); step();
        check_val("oneshot refire", 32'({done, tick}), 32'h44);
        ch_en = 4'b0000;
        step();
        oneshot = 4'b0000;

        // SYNC coincident with channel 0 terminal count, shadow 3 pending
        write_div(2'd2, 8'd3);
        write_div(2'd3, 8'd3);
        ch_en = 4'b1101;
        step();
        write_div(2'd0, 8'd3);
        check_val("sync pre pend", 32'(pend), 32'h1);
        step(); step();
        check_val("sync pre e3", 32'({wave, tick}), 32'hCC);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_val("sync edge", 32'({wave, tick, pend}), 32'h000);
        step(); step();
        check_val("sync e6", 32'(tick), 32'h0);
        step();
        check_val("sync aligned e7", 32'({wave, tick}), 32'hDD);
        ch_en = 4'b0000;
        step();

        // Out-of-range select is ignored
        div_we5 = 1'b1; div_sel5 = 3'd5; div_data5 = 8'd2;
        step();
        div_we5 = 1'b0;
        check_val("bad sel pend", 32'(pend5), 32'h0);
        ch_en5 = 5'b11111;
        step();
        step(); step(); step(); step();
        check_val("bad sel e4", 32'(tick5), 32'h0);
        step();
        check_val("bad sel e5", 32'(tick5), 32'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
